// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic round-robin arbiter.
//   DEFAULT_AW / DEFAULT_DW : default address and data widths.
//   arb_state_t             : arbiter FSM states.
//   onehot_to_idx()         : one-hot grant vector (up to 8 masters) to index.
package wb_pkg;

    localparam int DEFAULT_AW  = 32;
    localparam int DEFAULT_DW  = 32;
    localparam int MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // OR-reduction of indices: exact for a one-hot input, 0 for all-zero.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin priority encoder.
//   i_req   : per-requester request vector.
//   i_last  : index of the previous owner; scanning starts just above it.
//   o_pick  : one-hot winner (all-zero when nobody requests).
//   o_valid : at least one requester present.
module wb_rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_pick,
    output logic          o_valid
);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it holding an old value and infer a latch.
    always_comb begin
        int idx;
        idx     = 0;
        o_pick  = '0;
        o_valid = 1'b0;
        // Offsets 1..N visit every requester once, ending on the last owner.
        for (int off = 1; off <= N; off++) begin
            idx = int'(i_last) + off;
            if (idx >= N) idx = idx - N;
            if (!o_valid && i_req[idx]) begin
                o_pick[idx] = 1'b1;
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one slave port between
// NUM_MASTERS masters, with a watchdog that aborts never-completing accesses.
//   clk, reset              : clock and synchronous active-high reset.
//   m_cyc/m_stb/m_we        : per-master request, strobe, write enable.
//   m_adr/m_dat_w/m_sel     : packed per-master address, write data, selects.
//   m_ack/m_err             : completion routed only to the current owner.
//   m_dat_r                 : slave read data broadcast to all masters.
//   s_*                     : slave side, driven from the owner, zero when idle.
//   grant                   : one-hot current owner, all-zero when idle.
//   bus_timeout             : one-cycle pulse when the watchdog aborts.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = DEFAULT_AW,
    parameter int DW             = DEFAULT_DW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_w,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_sel,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [DW-1:0]                 m_dat_r,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [AW-1:0]                 s_adr,
    output logic [DW-1:0]                 s_dat_w,
    output logic [DW/8-1:0]               s_sel,
    input  logic [DW-1:0]                 s_dat_r,
    input  logic                          s_ack,
    input  logic                          s_err,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          bus_timeout
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_last;
    logic [CW-1:0]          r_cnt;

    logic [NUM_MASTERS-1:0] w_pick;
    logic                   w_pick_valid;
    logic [IW-1:0]          w_g_idx;
    logic                   w_active;
    logic                   w_stall;
    logic                   w_timeout;
    logic [CW-1:0]          w_cnt_inc;

    // Only cyc counts as a request; a stray stb without cyc never wins.
    wb_rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .i_req   (m_cyc),
        .i_last  (r_last),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    assign w_g_idx  = IW'(onehot_to_idx(MAX_MASTERS'(r_grant)));
    // The release cycle (owner's cyc already low) drives nothing to the slave.
    assign w_active = (r_state == BUSY) && m_cyc[w_g_idx];

    assign m_dat_r     = s_dat_r;
    assign grant       = r_grant;
    assign bus_timeout = (r_state == ABORT);

    always_comb begin
        s_cyc   = w_active;
        s_stb   = w_active & m_stb[w_g_idx];
        s_we    = w_active & m_we[w_g_idx];
        s_adr   = w_active ? m_adr[w_g_idx*AW +: AW]   : '0;
        s_dat_w = w_active ? m_dat_w[w_g_idx*DW +: DW] : '0;
        s_sel   = w_active ? m_sel[w_g_idx*SW +: SW]   : '0;
        m_ack   = '0;
        m_err   = '0;
        if (w_active) begin
            // err takes precedence when the slave reports both.
            m_ack[w_g_idx] = s_ack & ~s_err;
            m_err[w_g_idx] = s_err;
        end
        if (r_state == ABORT) m_err[w_g_idx] = 1'b1;
    end

    // A stalled cycle is a strobe with no answer. The abort is decided in the
    // stalled cycle that brings the count to the limit, so an ack/err in that
    // same cycle completes normally.
    assign w_stall   = s_stb & ~s_ack & ~s_err;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_stall && (w_cnt_inc == TO_VAL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_valid) begin
                        r_grant <= w_pick;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!m_cyc[w_g_idx]) begin
                        r_state <= IDLE;
                        r_last  <= w_g_idx;
                        r_grant <= '0;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= ABORT;
                        r_cnt   <= '0;
                    end else if (w_stall) begin
                        r_cnt <= w_cnt_inc;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ABORT: begin
                    r_cnt <= '0;
                    if (!m_cyc[w_g_idx]) begin
                        r_state <= IDLE;
                        r_last  <= w_g_idx;
                        r_grant <= '0;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
